alu_ctrl_stage: RTL and testbench

// - ID->EX producer of the ALU control interface: decodes alu_op/funct/opcode into the 4-bit ALU op code

---
 rtl/alu_ctrl_stage_if.sv | 31 +++
 rtl/alu_ctrl_stage.sv | 143 ++++++++++++++
 tb/tb_alu_ctrl_stage.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_stage_if.sv
// ID->EX ALU control bundle: decode inputs from the ID stage and the registered
// control the EX-stage ALU consumes.
interface alu_ctrl_stage_if #(
  parameter int N_BITS_CONTROL = 4,
  parameter int N_BITS_SHAMT   = 5,
  parameter int N_BITS_ERRCNT  = 8
);
  logic                      i_valid;
  logic                      i_stall;
  logic                      i_flush;
  logic [1:0]                i_alu_op;
  logic [5:0]                i_funct;
  logic [5:0]                i_opcode;
  logic [N_BITS_SHAMT-1:0]   i_shamt;
  logic                      o_valid;
  logic [N_BITS_CONTROL-1:0] o_alu_ctrl;
  logic                      o_shamt_sel;
  logic [N_BITS_SHAMT-1:0]   o_shamt;
  logic                      o_illegal;
  logic [N_BITS_ERRCNT-1:0]  o_err_cnt;

  // Master is the ID/pipeline-control side; slave is the stage itself.
  modport master (
    output i_valid, i_stall, i_flush, i_alu_op, i_funct, i_opcode, i_shamt,
    input  o_valid, o_alu_ctrl, o_shamt_sel, o_shamt, o_illegal, o_err_cnt
  );
  modport slave (
    input  i_valid, i_stall, i_flush, i_alu_op, i_funct, i_opcode, i_shamt,
    output o_valid, o_alu_ctrl, o_shamt_sel, o_shamt, o_illegal, o_err_cnt
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// ID->EX ALU control stage: decodes alu_op/funct/opcode into a 4-bit ALU code plus
// shift-amount select, one registered slot. Define ERR_CNT_EN for the illegal-op counter.
module alu_ctrl_stage #(
  parameter int N_BITS_CONTROL = 4,
  parameter int N_BITS_SHAMT   = 5,
  parameter int N_BITS_ERRCNT  = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  alu_ctrl_stage_if.slave bus
);
  typedef logic [N_BITS_CONTROL-1:0] ctrl_t;
  typedef logic [N_BITS_SHAMT-1:0]   shamt_t;

  localparam ctrl_t C_AND = 4'b0000;
  localparam ctrl_t C_OR  = 4'b0001;
  localparam ctrl_t C_ADD = 4'b0010;
  localparam ctrl_t C_NOR = 4'b0011;
  localparam ctrl_t C_XOR = 4'b0100;
  localparam ctrl_t C_SLL = 4'b0101;
  localparam ctrl_t C_SUB = 4'b0110;
  localparam ctrl_t C_SLT = 4'b0111;
  localparam ctrl_t C_SRL = 4'b1000;
  localparam ctrl_t C_SRA = 4'b1001;
  localparam ctrl_t C_NOP = 4'b1111;

  ctrl_t  dec_ctrl;
  logic   dec_sel;
  shamt_t dec_shamt;
  logic   dec_ill;

  always_comb begin
    dec_ctrl  = C_NOP;
    dec_sel   = 1'b0;
    dec_shamt = '0;
    dec_ill   = 1'b0;
    unique case (bus.i_alu_op)
      2'b00: dec_ctrl = C_ADD;
      2'b01: dec_ctrl = C_SUB;
      2'b10: begin
        case (bus.i_funct)
          6'b100000, 6'b100001: dec_ctrl = C_ADD;
          6'b100010, 6'b100011: dec_ctrl = C_SUB;
          6'b100100: dec_ctrl = C_AND;
          6'b100101: dec_ctrl = C_OR;
          6'b100110: dec_ctrl = C_XOR;
          6'b100111: dec_ctrl = C_NOR;
          6'b101010: dec_ctrl = C_SLT;
          6'b000000: begin dec_ctrl = C_SLL; dec_sel = 1'b1; dec_shamt = bus.i_shamt; end
          6'b000010: begin dec_ctrl = C_SRL; dec_sel = 1'b1; dec_shamt = bus.i_shamt; end
          6'b000011: begin dec_ctrl = C_SRA; dec_sel = 1'b1; dec_shamt = bus.i_shamt; end
          default:   dec_ill = 1'b1;
        endcase
      end
      default: begin
        case (bus.i_opcode)
          6'b001000, 6'b001001: dec_ctrl = C_ADD;
          6'b001010: dec_ctrl = C_SLT;
          6'b001100: dec_ctrl = C_AND;
          6'b001101: dec_ctrl = C_OR;
          6'b001110: dec_ctrl = C_XOR;
          // lui: shift the zero-extended immediate up by 16
          6'b001111: begin dec_ctrl = C_SLL; dec_sel = 1'b1; dec_shamt = shamt_t'(16); end
          default:   dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  logic   valid_q, valid_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   sel_q, sel_d;
  shamt_t shamt_q, shamt_d;
  logic   ill_q, ill_d;
  logic   load_ill;

  // A bubble is written on flush, or on a non-stalled edge with no real instruction.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    sel_d   = sel_q;
    shamt_d = shamt_q;
    ill_d   = ill_q;
    if (bus.i_flush || (!bus.i_stall && !bus.i_valid)) begin
      valid_d = 1'b0;
      ctrl_d  = C_NOP;
      sel_d   = 1'b0;
      shamt_d = '0;
      ill_d   = 1'b0;
    end else if (!bus.i_stall) begin
      valid_d = 1'b1;
      ctrl_d  = dec_ctrl;
      sel_d   = dec_sel;
      shamt_d = dec_shamt;
      ill_d   = dec_ill;
    end
  end

  assign load_ill = !bus.i_flush && !bus.i_stall && bus.i_valid && dec_ill;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= C_NOP;
      sel_q   <= 1'b0;
      shamt_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      sel_q   <= sel_d;
      shamt_q <= shamt_d;
      ill_q   <= ill_d;
    end
  end

`ifdef ERR_CNT_EN
  logic [N_BITS_ERRCNT-1:0] err_cnt_q, err_cnt_d;

  // Saturating: stops at all-ones, only reset clears it.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (load_ill && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) err_cnt_q <= '0;
    else         err_cnt_q <= err_cnt_d;
  end

  assign bus.o_err_cnt = err_cnt_q;
`else
  logic unused_load_ill;
  assign unused_load_ill = load_ill;
  assign bus.o_err_cnt   = '0;
`endif

  assign bus.o_valid     = valid_q;
  assign bus.o_alu_ctrl  = ctrl_q;
  assign bus.o_shamt_sel = sel_q;
  assign bus.o_shamt     = shamt_q;
  assign bus.o_illegal   = ill_q;
endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed-vector bench for alu_ctrl_stage; counter expectations follow ERR_CNT_EN.
module tb_alu_ctrl_stage;
`ifdef ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_reset;
  int   n_vec = 0;
  int   n_bad = 0;

  alu_ctrl_stage_if #(.N_BITS_CONTROL(4), .N_BITS_SHAMT(5), .N_BITS_ERRCNT(8)) bus ();

  alu_ctrl_stage #(.N_BITS_CONTROL(4), .N_BITS_SHAMT(5), .N_BITS_ERRCNT(8)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] op, input logic [5:0] fn,
                     input logic [5:0] opc, input logic [4:0] sh);
    bus.i_valid  = v;
    bus.i_alu_op = op;
    bus.i_funct  = fn;
    bus.i_opcode = opc;
    bus.i_shamt  = sh;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] c,
                         input logic s, input logic [4:0] sh, input logic il);
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(v));
    chk({tag, ".ctrl"},  32'(bus.o_alu_ctrl), 32'(c));
    chk({tag, ".sel"},   32'(bus.o_shamt_sel), 32'(s));
    chk({tag, ".shamt"}, 32'(bus.o_shamt), 32'(sh));
    chk({tag, ".ill"},   32'(bus.o_illegal), 32'(il));
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  initial begin
    i_reset = 1'b1;
    bus.i_stall = 1'b0;
    bus.i_flush = 1'b0;
    drv(1'b1, 2'b10, 6'b100000, 6'b0, 5'd3);
    step(); step();
    chk_out("reset", 1'b0, 4'b1111, 1'b0, 5'd0, 1'b0);
    chk("reset.cnt", 32'(bus.o_err_cnt), 32'd0);
    i_reset = 1'b0;

    drv(1'b1, 2'b10, 6'b000011, 6'b0, 5'd7); step();
    chk_out("sra", 1'b1, 4'b1001, 1'b1, 5'd7, 1'b0);
    drv(1'b1, 2'b11, 6'b0, 6'b001111, 5'd3); step();
    chk_out("lui", 1'b1, 4'b0101, 1'b1, 5'd16, 1'b0);
    drv(1'b1, 2'b11, 6'b0, 6'b001010, 5'd3); step();
    chk_out("slti", 1'b1, 4'b0111, 1'b0, 5'd0, 1'b0);
    drv(1'b1, 2'b10, 6'b000000, 6'b0, 5'd0); step();
    chk_out("nop", 1'b1, 4'b0101, 1'b1, 5'd0, 1'b0);
    drv(1'b1, 2'b10, 6'b000010, 6'b0, 5'd31); step();
    chk_out("srl", 1'b1, 4'b1000, 1'b1, 5'd31, 1'b0);
    drv(1'b1, 2'b10, 6'b100111, 6'b0, 5'd9); step();
    chk_out("nor", 1'b1, 4'b0011, 1'b0, 5'd0, 1'b0);
    drv(1'b1, 2'b00, 6'b111111, 6'b111111, 5'd4); step();
    chk_out("ldst", 1'b1, 4'b0010, 1'b0, 5'd0, 1'b0);
    drv(1'b1, 2'b01, 6'b111111, 6'b000000, 5'd4); step();
    chk_out("br", 1'b1, 4'b0110, 1'b0, 5'd0, 1'b0);
    drv(1'b1, 2'b11, 6'b0, 6'b001110, 5'd0); step();
    chk_out("xori", 1'b1, 4'b0100, 1'b0, 5'd0, 1'b0);

    // Load OR, then hold through a 3-cycle stall while inputs change to SUB
    drv(1'b1, 2'b10, 6'b100101, 6'b0, 5'd0); step();
    chk_out("or", 1'b1, 4'b0001, 1'b0, 5'd0, 1'b0);
    bus.i_stall = 1'b1;
    drv(1'b1, 2'b10, 6'b100010, 6'b0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.ctrl", 32'(bus.o_alu_ctrl), 32'b0001);
    end
    bus.i_stall = 1'b0; step();
    chk_out("unstall", 1'b1, 4'b0110, 1'b0, 5'd0, 1'b0);

    bus.i_stall = 1'b1; bus.i_flush = 1'b1; step();
    chk_out("stflush", 1'b0, 4'b1111, 1'b0, 5'd0, 1'b0);
    bus.i_stall = 1'b0; bus.i_flush = 1'b0;
    drv(1'b0, 2'b10, 6'b000011, 6'b0, 5'd7); step();
    chk_out("bubble", 1'b0, 4'b1111, 1'b0, 5'd0, 1'b0);
    chk("cnt0", 32'(bus.o_err_cnt), 32'd0);

    // Illegal R-type for 3 loads, then one stalled edge
    drv(1'b1, 2'b10, 6'b111111, 6'b0, 5'd7);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk_out("illr", 1'b1, 4'b1111, 1'b0, 5'd0, 1'b1);
      chk("illr.cnt", 32'(bus.o_err_cnt), exp_cnt(i));
    end
    bus.i_stall = 1'b1; step();
    chk("ill.stall", 32'(bus.o_illegal), 32'd1);
    chk("ill.stall.cnt", 32'(bus.o_err_cnt), exp_cnt(3));
    bus.i_stall = 1'b0;
    drv(1'b0, 2'b10, 6'b111111, 6'b0, 5'd0); step();
    chk_out("ill.inv", 1'b0, 4'b1111, 1'b0, 5'd0, 1'b0);
    chk("ill.inv.cnt", 32'(bus.o_err_cnt), exp_cnt(3));
    drv(1'b1, 2'b11, 6'b0, 6'b000000, 5'd0);
    bus.i_flush = 1'b1; step();
    chk_out("ill.flush", 1'b0, 4'b1111, 1'b0, 5'd0, 1'b0);
    chk("ill.flush.cnt", 32'(bus.o_err_cnt), exp_cnt(3));
    bus.i_flush = 1'b0; step();
    chk_out("illi", 1'b1, 4'b1111, 1'b0, 5'd0, 1'b1);
    chk("illi.cnt", 32'(bus.o_err_cnt), exp_cnt(4));

    for (int i = 0; i < 300; i++) step();
    chk("sat.cnt", 32'(bus.o_err_cnt), exp_cnt(255));
    chk("sat.ill", 32'(bus.o_illegal), 32'd1);

    // Reset wins over a simultaneous stall
    bus.i_stall = 1'b1; i_reset = 1'b1; step();
    chk_out("rststall", 1'b0, 4'b1111, 1'b0, 5'd0, 1'b0);
    chk("rststall.cnt", 32'(bus.o_err_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
